// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - handshaked execute-stage ALU with iterative RV32M multiply/divide
//
// Registered-result ALU for the execute stage. Base integer, branch-compare,
// address and upper-immediate ops complete in one cycle; MUL/MULH/MULHSU/MULHU
// use a shift-add multiplier and DIV/DIVU/REM/REMU a restoring divider, both
// one bit per cycle over operand magnitudes with the sign applied at the end.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   valid_i / ready_o      request handshake (a_i, b_i, aluctrl_i captured)
//   kill_i                 abandon in-flight work / suppress acceptance
//   valid_o / ready_i      result handshake (result_o, zero_o held until taken)
//   busy_o                 iterative multiply or divide in progress
//
// Build option: ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier.
module alu_mdu #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [CTRL_W-1:0] aluctrl_i,
    input  logic              kill_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              zero_o,
    output logic              busy_o
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CTRL_W-1:0] OP_SUB    = CTRL_W'(5'b00000);
    localparam logic [CTRL_W-1:0] OP_ADD    = CTRL_W'(5'b00001);
    localparam logic [CTRL_W-1:0] OP_SLL    = CTRL_W'(5'b00010);
    localparam logic [CTRL_W-1:0] OP_SLT    = CTRL_W'(5'b00011);
    localparam logic [CTRL_W-1:0] OP_SLTU   = CTRL_W'(5'b00100);
    localparam logic [CTRL_W-1:0] OP_XOR    = CTRL_W'(5'b00101);
    localparam logic [CTRL_W-1:0] OP_SRA    = CTRL_W'(5'b00110);
    localparam logic [CTRL_W-1:0] OP_SRL    = CTRL_W'(5'b00111);
    localparam logic [CTRL_W-1:0] OP_OR     = CTRL_W'(5'b01000);
    localparam logic [CTRL_W-1:0] OP_AND    = CTRL_W'(5'b01001);
    localparam logic [CTRL_W-1:0] OP_LDST   = CTRL_W'(5'b01010);
    localparam logic [CTRL_W-1:0] OP_MUL    = CTRL_W'(5'b01100);
    localparam logic [CTRL_W-1:0] OP_MULH   = CTRL_W'(5'b01101);
    localparam logic [CTRL_W-1:0] OP_MULHSU = CTRL_W'(5'b01110);
    localparam logic [CTRL_W-1:0] OP_MULHU  = CTRL_W'(5'b01111);
    localparam logic [CTRL_W-1:0] OP_DIV    = CTRL_W'(5'b10000);
    localparam logic [CTRL_W-1:0] OP_DIVU   = CTRL_W'(5'b10001);
    localparam logic [CTRL_W-1:0] OP_BEQ    = CTRL_W'(5'b10010);
    localparam logic [CTRL_W-1:0] OP_BNE    = CTRL_W'(5'b10011);
    localparam logic [CTRL_W-1:0] OP_BLT    = CTRL_W'(5'b10100);
    localparam logic [CTRL_W-1:0] OP_BGE    = CTRL_W'(5'b10101);
    localparam logic [CTRL_W-1:0] OP_BLTU   = CTRL_W'(5'b10110);
    localparam logic [CTRL_W-1:0] OP_BGEU   = CTRL_W'(5'b10111);
    localparam logic [CTRL_W-1:0] OP_JALR   = CTRL_W'(5'b11001);
    localparam logic [CTRL_W-1:0] OP_LUI    = CTRL_W'(5'b11010);
    localparam logic [CTRL_W-1:0] OP_REM    = CTRL_W'(5'b11100);
    localparam logic [CTRL_W-1:0] OP_REMU   = CTRL_W'(5'b11101);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
    logic            neg_q, neg_d;     // negate final magnitude
    logic            sel_q, sel_d;     // mul: take high half; div: take remainder
    logic [SH_W-1:0] cnt_q, cnt_d;

    // Decode of the request presented this cycle
    logic [XLEN-1:0] base_res, a_mag, b_mag, special_res;
    logic            is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg, is_rem, div_special, launch;
    logic            slt_s, slt_u;

    assign slt_s = $signed(a_i) < $signed(b_i);
    assign slt_u = a_i < b_i;

    always_comb begin
        base_res = '0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        case (aluctrl_i)
            OP_SUB:              base_res = a_i - b_i;
            OP_ADD, OP_LDST,
            OP_JALR:             base_res = a_i + b_i;
            OP_SLL:              base_res = a_i << b_i[SH_W-1:0];
            OP_SLT:              base_res = XLEN'(slt_s);
            OP_SLTU:             base_res = XLEN'(slt_u);
            OP_XOR:              base_res = a_i ^ b_i;
            OP_SRA:              base_res = $signed(a_i) >>> b_i[SH_W-1:0];
            OP_SRL:              base_res = a_i >> b_i[SH_W-1:0];
            OP_OR:               base_res = a_i | b_i;
            OP_AND:              base_res = a_i & b_i;
            // Branch compares report 1 when the branch is NOT taken
            OP_BEQ:              base_res = XLEN'(a_i != b_i);
            OP_BNE:              base_res = XLEN'(a_i == b_i);
            OP_BLT:              base_res = XLEN'(!slt_s);
            OP_BGE:              base_res = XLEN'(slt_s);
            OP_BLTU:             base_res = XLEN'(!slt_u);
            OP_BGEU:             base_res = XLEN'(slt_u);
            OP_LUI:              base_res = b_i;
            OP_MUL, OP_MULH:     begin is_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_MULHSU:           begin is_mul = 1'b1; a_sgn = 1'b1; end
            OP_MULHU:            is_mul = 1'b1;
            OP_DIV, OP_REM:      begin is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_DIVU, OP_REMU:    is_div = 1'b1;
            default:             base_res = '0;   // jal, auipc and unused codes
        endcase
    end

    assign a_neg  = a_sgn & a_i[XLEN-1];
    assign b_neg  = b_sgn & b_i[XLEN-1];
    assign a_mag  = a_neg ? -a_i : a_i;
    assign b_mag  = b_neg ? -b_i : b_i;
    assign is_rem = (aluctrl_i == OP_REM) || (aluctrl_i == OP_REMU);

    // Divide-by-zero and signed overflow resolve without iterating
    assign div_special = (b_i == '0) || (a_sgn && a_i == MIN_VAL && b_i == '1);
    assign special_res = (b_i == '0) ? (is_rem ? a_i : '1) : (is_rem ? '0 : MIN_VAL);

`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    assign fast_mag  = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
    assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`else
    // Shift-add step: add multiplicand into the high half, shift the whole product right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_prod, mul_fix;
    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_prod = {mul_sum, lo_q[XLEN-1:1]};
    assign mul_fix  = neg_q ? -mul_prod : mul_prod;
`endif

    // Restoring step: shift in the next dividend bit, keep the difference if non-negative
    logic [XLEN:0]   div_sh, div_diff;
    logic [XLEN-1:0] div_rem_n, div_quo_n, div_mag;
    logic            div_ok;
    assign div_sh    = {acc_q, lo_q[XLEN-1]};
    assign div_diff  = div_sh - {1'b0, opnd_q};
    assign div_ok    = !div_diff[XLEN];
    assign div_rem_n = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_quo_n = {lo_q[XLEN-2:0], div_ok};
    assign div_mag   = sel_q ? div_rem_n : div_quo_n;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        launch   = 1'b0;

        if (kill_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: launch = valid_i;
                S_MUL: begin
`ifndef ALU_MDU_FAST_MUL_EN
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SH_W'(XLEN-1)) begin
                        result_d = sel_q ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0];
                        state_d  = S_DONE;
                    end
`endif
                end
                S_DIV: begin
                    acc_d = div_rem_n;
                    lo_d  = div_quo_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SH_W'(XLEN-1)) begin
                        result_d = neg_q ? -div_mag : div_mag;
                        state_d  = S_DONE;
                    end
                end
                default: begin   // S_DONE
                    if (ready_i) begin
                        launch  = valid_i;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end

        if (launch) begin
            state_d = S_DONE;
            if (is_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
                result_d = (aluctrl_i == OP_MUL) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
`else
                acc_d   = '0;
                lo_d    = b_mag;
                opnd_d  = a_mag;
                neg_d   = a_neg ^ b_neg;
                sel_d   = (aluctrl_i != OP_MUL);
                cnt_d   = '0;
                state_d = S_MUL;
`endif
            end else if (is_div && div_special) begin
                result_d = special_res;
            end else if (is_div) begin
                acc_d   = '0;
                lo_d    = a_mag;
                opnd_d  = b_mag;
                neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
                sel_d   = is_rem;
                cnt_d   = '0;
                state_d = S_DIV;
            end else begin
                result_d = base_res;
            end
        end

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE) || (state_q == S_DONE && ready_i);
    assign valid_o  = (state_q == S_DONE);
    assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
    assign result_o = result_q;
    assign zero_o   = zero_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;
    localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00000, SLL = 5'b00010, XOR = 5'b00101;
    localparam logic [4:0] MUL = 5'b01100, MULH = 5'b01101, MULHSU = 5'b01110, MULHU = 5'b01111;
    localparam logic [4:0] DIV = 5'b10000, DIVU = 5'b10001, REM = 5'b11100, REMU = 5'b11101;
    localparam logic [4:0] BEQ = 5'b10010, BNE = 5'b10011, BAD = 5'b11111;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b1, kill_i = 1'b0;
    logic [31:0] a_i = '0, b_i = '0;
    logic [4:0]  aluctrl_i = '0;
    logic        ready_o, valid_o, zero_o, busy_o;
    logic [31:0] result_o;

    int vectors = 0;
    int miscompares = 0;
    int lat, bsy, seen;

    alu_mdu #(.XLEN(32), .CTRL_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .aluctrl_i(aluctrl_i), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        aluctrl_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    // Called one cycle after the accepting edge; lat counts cycles from accept to valid_o
    task automatic wait_valid(output int l, output int b);
        l = 1; b = 0;
        while (!valid_o && l < 60) begin
            if (busy_o) b++;
            tick();
            l++;
        end
    endtask

    task automatic op_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int l, bz;
        issue(op, a, b);
        wait_valid(l, bz);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_res"}, result_o, exp);
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_zero", zero_o, 1);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", ready_o, 1);

        // Back-to-back base ops, one per cycle
        aluctrl_i = ADD; a_i = 5; b_i = 3; valid_i = 1'b1;
        tick();
        chk("b2b_add", result_o, 32'd8);
        chk("b2b_add_valid", valid_o, 1);
        chk("b2b_add_zero", zero_o, 0);
        aluctrl_i = SUB; a_i = 5; b_i = 5;
        tick();
        chk("b2b_sub", result_o, 32'd0);
        chk("b2b_sub_zero", zero_o, 1);
        chk("b2b_sub_valid", valid_o, 1);
        aluctrl_i = SLL; a_i = 1; b_i = 31;
        tick();
        chk("b2b_sll", result_o, 32'h8000_0000);
        chk("b2b_sll_valid", valid_o, 1);
        valid_i = 1'b0;
        tick();
        chk("b2b_idle", valid_o, 0);

        // Iterative signed divide / remainder
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_valid(lat, bsy);
        chk("div_lat", lat, 33);
        chk("div_busy", bsy, 32);
        chk("div_res", result_o, 32'hFFFF_FFFD);
        tick();
        issue(REM, 32'hFFFF_FFF9, 32'd2);
        wait_valid(lat, bsy);
        chk("rem_lat", lat, 33);
        chk("rem_busy", bsy, 32);
        chk("rem_res", result_o, 32'hFFFF_FFFF);
        tick();
        op_check("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33);
        op_check("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33);

        // Divide special cases
        op_check("divu_by0", DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 1);
        op_check("rem_by0", REM, 32'd10, 32'd0, 32'd10, 1);
        op_check("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        op_check("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Multiply group
        op_check("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
        op_check("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        op_check("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
        op_check("mul_wrap", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, MUL_LAT);
        op_check("mul_neg", MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, MUL_LAT);

        // Branch compares and unused opcode
        op_check("beq_eq", BEQ, 32'd9, 32'd9, 32'd0, 1);
        op_check("bne_eq", BNE, 32'd9, 32'd9, 32'd1, 1);
        op_check("bad_op", BAD, 32'd5, 32'd6, 32'd0, 1);

        // Stall: result held while ready_i is low
        ready_i = 1'b0;
        issue(XOR, 32'hF0, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_res", result_o, 32'hFF);
            chk("stall_ready", ready_o, 0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        chk("stall_release", valid_o, 0);

        // Kill while a result waits, and kill in IDLE
        ready_i = 1'b0;
        issue(ADD, 32'd1, 32'd1);
        chk("kdone_pre", valid_o, 1);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kdone_valid", valid_o, 0);
        ready_i = 1'b1;
        kill_i = 1'b1;
        issue(ADD, 32'd2, 32'd2);
        kill_i = 1'b0;
        chk("kidle_valid", valid_o, 0);
        chk("kidle_ready", ready_o, 1);

        // Kill at cycle 10 of a multiply
        issue(MUL, 32'd3, 32'd5);
        repeat (8) tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kmul_valid", valid_o, 0);
        chk("kmul_busy", busy_o, 0);
        chk("kmul_ready", ready_o, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen++;
            tick();
        end
        chk("kmul_no_valid", seen, 0);
        op_check("mul_after_kill", MUL, 32'd3, 32'd5, 32'd15, MUL_LAT);

        // Reset in the middle of a divide
        issue(DIVU, 32'd100, 32'd7);
        repeat (3) tick();
        rst_ni = 1'b0;
        tick();
        chk("rdiv_valid", valid_o, 0);
        chk("rdiv_busy", busy_o, 0);
        chk("rdiv_result", result_o, 0);
        chk("rdiv_zero", zero_o, 1);
        rst_ni = 1'b1;
        tick();
        chk("rdiv_ready", ready_o, 1);
        op_check("add_after_rst", ADD, 32'd40, 32'd2, 32'd42, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor of the single-cycle execute ALU.
- Keeps the integer, branch-compare, address and upper-immediate operations, and adds the RV32M multiply/divide group.
- The result is registered. Multiply and divide are iterative multi-cycle operations.
- Sits in the execute stage between the operand muxes and the writeback/branch logic. The pipeline stalls on `ready_o`/`valid_o`.

Parameters:
- XLEN, 32, operand/result width; any value ≥ 8; shift amount is `b_i[$clog2(XLEN)-1:0]`.
- CTRL_W, 5, width of `aluctrl_i`.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  block can accept a request this cycle
- a_i  in  XLEN  operand A
- b_i  in  XLEN  operand B
- aluctrl_i  in  CTRL_W  operation select
- kill_i  in  1  abandon the in-flight operation (pipeline flush)
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result
- result_o  out  XLEN  registered result
- zero_o  out  1  registered (result_o == 0)
- busy_o  out  1  iterative operation in progress

Behaviour:
- Opcode map:
  - 00000 sub; 00001 add; 00010 sll; 00011 slt; 00100 sltu; 00101 xor; 00110 sra; 00111 srl; 01000 or; 01001 and.
  - 01010 ld/st add.
  - 10010–10111 branch compares. Result is 1 when the branch is NOT taken: beq, bne, blt, bge, bltu, bgeu.
  - 11000 jal → 0; 11001 jalr → a+b; 11010 lui → b; 11011 auipc → 0.
  - New codes: 01100 MUL, 01101 MULH, 01110 MULHSU, 01111 MULHU, 10000 DIV, 10001 DIVU, 11100 REM, 11101 REMU.
  - Any other code → result 0, latency 1.
- Arithmetic is modulo 2^XLEN. MULH* returns the upper XLEN bits of the 2·XLEN-bit product under RISC-V signedness rules.
- States:
  - IDLE: `ready_o` = 1.
  - MUL_BUSY, DIV_BUSY: `busy_o` = 1, `ready_o` = 0.
  - DONE: `valid_o` = 1.
- Accept: `valid_i && ready_o` on a clock edge; operands and opcode are captured.
  - Base op or special-case divide: IDLE → DONE. `valid_o` is high on the next cycle (latency 1).
  - MUL group: shift-add, one bit per cycle, over magnitudes with the sign fixed at the end. IDLE → MUL_BUSY for XLEN cycles, then DONE. Latency XLEN+1.
  - DIV group: restoring divide, one quotient bit per cycle, over magnitudes. IDLE → DIV_BUSY for XLEN cycles, then DONE. Latency XLEN+1. Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide special cases (latency 1, no iteration):
  - b == 0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (a == min, b == -1, DIV/REM only): DIV → min; REM → 0.
- DONE:
  - `result_o` and `zero_o` stay stable until `valid_o && ready_i`.
  - `ready_o` = `ready_i`, so a new request may be accepted in the same cycle the result is taken (back-to-back base ops at 1 per cycle).
  - If the result is taken and no new request arrives → IDLE.
- `kill_i`:
  - In MUL_BUSY/DIV_BUSY or DONE: → IDLE next cycle; `valid_o` deasserts; the result is discarded.
  - In IDLE, `kill_i` suppresses acceptance that cycle.
  - `kill_i` has priority over `valid_i` and `ready_i`.
- Inputs are ignored while `ready_o` = 0. Operand changes during BUSY have no effect.
- Reset (`rst_ni` = 0 at a clock edge, any state, including mid-iteration):
  - State → IDLE.
  - `valid_o` = 0, `busy_o` = 0, `result_o` = 0, `zero_o` = 1.
  - Internal counters and accumulators cleared.
  - `ready_o` = 1 after the first edge with `rst_ni` = 1.

Optional Feature:
- ALU_MDU_FAST_MUL_EN
  - Defined: the MUL group uses a single-cycle XLEN×XLEN multiplier. IDLE → DONE with latency 1; MUL_BUSY is never entered.
  - Undefined: iterative multiplier, latency XLEN+1.
  - The divide path is unchanged in both builds.

Test Plan:
- Reset mid-DIV: accept DIVU 100/7, assert `rst_ni` = 0 at cycle 5 → next cycle `valid_o` = 0, `busy_o` = 0, `result_o` = 0, `zero_o` = 1, `ready_o` = 1.
- Back-to-back base ops with `ready_i` held 1: add 5+3, sub 5−5, sll 1<<31 → results 8, 0 (`zero_o` = 1), 0x80000000 on consecutive cycles, each latency 1.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. Each with `valid_o` exactly 33 cycles after accept; `busy_o` high for 32 cycles.
- Special-case divides:
  - DIVU 10/0 → 0xFFFFFFFF; REM 10/0 → 10.
  - DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
  - All with latency 1.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF; MUL 0x10000×0x10000 → 0.
  - Latency 33, or 1 with ALU_MDU_FAST_MUL_EN.
- Stall and kill:
  - Result held under `ready_i` = 0 for 4 cycles → `result_o` stable, `valid_o` stays 1.
  - `kill_i` at cycle 10 of a MUL → IDLE next cycle, no `valid_o`.
  - Branch opcode 10010 with a == b → result 0.
